fifo_wr_arbiter: RTL and testbench

Round-robin write-port arbiter that shares the single 16-deep x 4-bit FIFO write port between NUM_REQ producers.
- Sits between the producers and the FIFO's wr_en/datain pins.
- Grants one producer at a time for a bounded burst.
- Guards against writing into a full FIFO. The FIFO write pointer advances on every wr_en, so this block is the only overflow guard.

---
 rtl/fifo_arb_pkg.sv | 19 +
 rtl/fifo_wr_arbiter_if.sv | 26 ++
 rtl/fifo_wr_arbiter_rr_pick.sv | 31 +++
 rtl/fifo_wr_arbiter.sv | 98 +++++++++
 tb/tb_fifo_wr_arbiter.sv | 248 ++++++++++++++++++++++++
 5 files changed

// File: rtl/fifo_arb_pkg.sv
// Shared types and defaults for the FIFO write-port arbiter.
// Index widths are derived here so every file agrees on them.
package fifo_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } arb_state_t;

  localparam int DEF_DATA_W = 4;
  localparam int FIFO_DEPTH = 16;
  localparam int CNT_W      = 4;

  // Width of a producer index; never below 1 so vectors stay legal.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// Producer/FIFO-side signal bundle for the write-port arbiter.
// The arbiter uses the slave view; producers and the FIFO model use master.
interface fifo_wr_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = fifo_arb_pkg::DEF_DATA_W
);
  logic [NUM_REQ-1:0]             req;
  logic [NUM_REQ-1:0][DATA_W-1:0] req_data;
  logic                           fifo_full;
  logic [NUM_REQ-1:0]             ack;
  logic [NUM_REQ-1:0]             grant;
  logic                           fifo_wr_en;
  logic [DATA_W-1:0]              fifo_datain;
  logic                           busy;
  logic                           stall;

  modport master (
    output req, req_data, fifo_full,
    input  ack, grant, fifo_wr_en, fifo_datain, busy, stall
  );

  modport slave (
    input  req, req_data, fifo_full,
    output ack, grant, fifo_wr_en, fifo_datain, busy, stall
  );
endinterface

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Rotating-priority encoder: first set req bit scanning from rr_ptr upward
// with wrap at NUM_REQ (explicit compare-and-subtract for non-power-of-2 counts).
module rr_pick
  import fifo_arb_pkg::*;
#(
  parameter  int NUM_REQ = 4,
  localparam int IW      = idx_w(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IW-1:0]      rr_ptr,
  output logic [IW-1:0]      sel,
  output logic               any_req
);

  localparam logic [IW:0] NR = (IW+1)'(NUM_REQ);

  logic [IW:0] pos;

  // Walk from lowest to highest priority so the last hit wins.
  always_comb begin
    sel     = '0;
    pos     = '0;
    any_req = |req;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      pos = {1'b0, rr_ptr} + (IW+1)'(k);
      if (pos >= NR) pos = pos - NR;
      if (req[pos[IW-1:0]]) sel = pos[IW-1:0];
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NUM_REQ producers,
// with bounded bursts and the only overflow guard in front of the FIFO.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int DATA_W    = DEF_DATA_W,
  parameter int MAX_BURST = 4
) (
  input logic          clk,
  input logic          reset,
  fifo_wr_arbiter_if.slave bus
);

  localparam int              IW       = idx_w(NUM_REQ);
  localparam logic [IW-1:0]   LAST_IDX = IW'(NUM_REQ - 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MAX_BURST - 1);

  arb_state_t         state, state_n;
  logic [NUM_REQ-1:0] grant_q, grant_n;
  logic [IW-1:0]      g_idx, g_idx_n;
  logic [IW-1:0]      rr_ptr, rr_ptr_n;
  logic [CNT_W-1:0]   burst_cnt, burst_cnt_n;
  logic [IW-1:0]      sel;
  logic               any_req;
  logic               in_burst;
  logic               cur_req;
  logic               wr;
  logic [DATA_W-1:0]  word;

  rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .req     (bus.req),
    .rr_ptr  (rr_ptr),
    .sel     (sel),
    .any_req (any_req)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      grant_q   <= '0;
      g_idx     <= '0;
      rr_ptr    <= '0;
      burst_cnt <= '0;
    end else begin
      state     <= state_n;
      grant_q   <= grant_n;
      g_idx     <= g_idx_n;
      rr_ptr    <= rr_ptr_n;
      burst_cnt <= burst_cnt_n;
    end
  end

  always_comb begin
    in_burst    = (state == BURST);
    cur_req     = bus.req[g_idx];
    // Never write while full: the FIFO pointer moves on every wr_en.
    wr          = in_burst & cur_req & ~bus.fifo_full;
    word        = in_burst ? bus.req_data[g_idx] : '0;

    state_n     = state;
    grant_n     = grant_q;
    g_idx_n     = g_idx;
    rr_ptr_n    = rr_ptr;
    burst_cnt_n = burst_cnt;

    case (state)
      IDLE: begin
        if (any_req) begin
          state_n      = BURST;
          grant_n      = '0;
          grant_n[sel] = 1'b1;
          g_idx_n      = sel;
          burst_cnt_n  = '0;
        end
      end
      BURST: begin
        if (wr) burst_cnt_n = burst_cnt + CNT_W'(1);
        // A stalled burst holds the grant until req drops or space appears.
        if (!cur_req || (wr && burst_cnt == LAST_CNT)) begin
          state_n     = IDLE;
          grant_n     = '0;
          burst_cnt_n = '0;
          rr_ptr_n    = (g_idx == LAST_IDX) ? '0 : g_idx + IW'(1);
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign bus.grant       = grant_q;
  assign bus.fifo_wr_en  = wr;
  assign bus.ack         = wr ? grant_q : '0;
  assign bus.fifo_datain = word;
  assign bus.busy        = in_burst;
  assign bus.stall       = in_burst & cur_req & bus.fifo_full;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: queue-based producer/arbiter model checked every
// cycle, directed scenarios pinned with literal expectations, then random traffic.
module tb_fifo_wr_arbiter;
  localparam int NR = 4;
  localparam int DW = 4;
  localparam int MB = 4;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;

  fifo_wr_arbiter_if #(.NUM_REQ(NR), .DATA_W(DW)) bus ();

  fifo_wr_arbiter #(.NUM_REQ(NR), .DATA_W(DW), .MAX_BURST(MB)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Producer word queues; head is the word currently presented.
  logic [DW-1:0] pq [NR][$];
  logic          full_v = 1'b0;

  // Reference model state
  bit m_busy;
  int m_owner, m_cnt, m_ptr;

  // Observation logs
  int            w_cyc [$];
  logic [DW-1:0] w_dat [$];
  logic [NR-1:0] w_ack [$];
  logic [NR-1:0] g_log [$];
  logic [NR-1:0] prev_grant;
  int            stall_cnt, viol_cnt;

  int exp_cyc1 [6] = '{1, 2, 3, 4, 6, 7};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d actual=%0h expected=%0h", name, cyc, act, exp);
    end
  endtask

  function automatic bit any_q();
    for (int i = 0; i < NR; i++) if (pq[i].size() != 0) return 1'b1;
    return 1'b0;
  endfunction

  task automatic drive();
    for (int i = 0; i < NR; i++) begin
      bus.req[i]      = (pq[i].size() != 0);
      bus.req_data[i] = (pq[i].size() != 0) ? pq[i][0] : '0;
    end
    bus.fifo_full = full_v;
  endtask

  task automatic clear_logs();
    w_cyc.delete(); w_dat.delete(); w_ack.delete(); g_log.delete();
    stall_cnt = 0; viol_cnt = 0;
  endtask

  task automatic step();
    logic [NR-1:0] e_grant, e_ack;
    logic [DW-1:0] e_dat;
    logic          rq, e_wr, e_stall;
    drive();
    @(negedge clk);
    rq      = m_busy && (pq[m_owner].size() != 0);
    e_wr    = rq && !full_v;
    e_stall = rq && full_v;
    e_grant = '0;
    if (m_busy) e_grant[m_owner] = 1'b1;
    e_ack   = e_wr ? e_grant : '0;
    e_dat   = rq ? pq[m_owner][0] : '0;
    chk("grant",  bus.grant,       e_grant);
    chk("ack",    bus.ack,         e_ack);
    chk("wr_en",  bus.fifo_wr_en,  e_wr);
    chk("datain", bus.fifo_datain, e_dat);
    chk("busy",   bus.busy,        m_busy);
    chk("stall",  bus.stall,       e_stall);
    if (bus.fifo_wr_en === 1'b1) begin
      w_cyc.push_back(cyc); w_dat.push_back(bus.fifo_datain); w_ack.push_back(bus.ack);
    end
    if (bus.grant != '0 && prev_grant == '0) g_log.push_back(bus.grant);
    prev_grant = bus.grant;
    if (bus.stall === 1'b1) stall_cnt++;
    if (bus.fifo_wr_en === 1'b1 && bus.fifo_full === 1'b1) viol_cnt++;
    @(posedge clk);
    if (!m_busy) begin
      for (int k = 0; k < NR; k++) begin
        int j;
        j = (m_ptr + k) % NR;
        if (pq[j].size() != 0) begin
          m_busy = 1'b1; m_owner = j; m_cnt = 0;
          break;
        end
      end
    end else begin
      if (e_wr) begin
        void'(pq[m_owner].pop_front());
        m_cnt++;
      end
      if (!rq || m_cnt == MB) begin
        m_busy = 1'b0;
        m_ptr  = (m_owner + 1) % NR;
      end
    end
    cyc++;
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    #1;
    chk("rst_wr_en", bus.fifo_wr_en, 0);
    chk("rst_grant", bus.grant,      0);
    chk("rst_ack",   bus.ack,        0);
    chk("rst_busy",  bus.busy,       0);
    chk("rst_stall", bus.stall,      0);
    m_busy = 1'b0; m_cnt = 0; m_ptr = 0; m_owner = 0;
    prev_grant = '0;
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  task automatic drain(input int maxc);
    int n;
    n = 0;
    while ((m_busy || any_q()) && n < maxc) begin
      step();
      n++;
    end
    chk("drain_done", (m_busy || any_q()) ? 1 : 0, 0);
  endtask

  initial begin
    int base;
    drive();
    #2;
    do_reset();

    // Single requester, words 1..6
    clear_logs();
    for (int v = 1; v <= 6; v++) pq[0].push_back(DW'(v));
    base = cyc;
    drain(40);
    chk("s1_nwr", w_dat.size(), 6);
    for (int i = 0; i < 6 && i < w_dat.size(); i++) begin
      chk("s1_data", w_dat[i], i + 1);
      chk("s1_cyc",  w_cyc[i] - base, exp_cyc1[i]);
    end
    if (g_log.size() > 0) chk("s1_grant", g_log[0], 4'b0001);
    else chk("s1_grant_seen", 0, 1);

    // All four requesters continuously active
    do_reset();
    clear_logs();
    for (int i = 0; i < NR; i++)
      for (int v = 0; v < 8; v++) pq[i].push_back(DW'($urandom));
    drain(80);
    chk("s2_nwr", w_ack.size(), 32);
    for (int k = 0; k < 32 && k < w_ack.size(); k++)
      chk("s2_rot", w_ack[k], 1 << ((k / 4) % 4));

    // FIFO full after the 2nd word
    do_reset();
    clear_logs();
    for (int v = 1; v <= 4; v++) pq[0].push_back(DW'(v));
    repeat (3) step();
    full_v = 1'b1;
    repeat (3) step();
    full_v = 1'b0;
    drain(20);
    chk("s3_stalls", stall_cnt, 3);
    chk("s3_viol",   viol_cnt,  0);
    chk("s3_nwr",    w_dat.size(), 4);
    for (int i = 0; i < 4 && i < w_dat.size(); i++) chk("s3_data", w_dat[i], i + 1);

    // Requester 2 drops after 2 words while requester 3 waits
    do_reset();
    clear_logs();
    pq[2].push_back(4'd5); pq[2].push_back(4'd6);
    pq[3].push_back(4'd7); pq[3].push_back(4'd8); pq[3].push_back(4'd9);
    drain(30);
    chk("s4_nwr", w_ack.size(), 5);
    if (w_ack.size() >= 3) begin
      chk("s4_ack0", w_ack[0], 4'b0100);
      chk("s4_ack2", w_ack[2], 4'b1000);
    end
    if (g_log.size() >= 2) chk("s4_grant2", g_log[1], 4'b1000);
    else chk("s4_grants", g_log.size(), 2);

    // Reset mid-burst after the 2nd write
    do_reset();
    clear_logs();
    for (int v = 1; v <= 6; v++) pq[1].push_back(DW'(v));
    repeat (3) step();
    chk("s5_pre_nwr", w_dat.size(), 2);
    do_reset();
    clear_logs();
    pq[0].push_back(4'd10); pq[0].push_back(4'd11);
    drain(40);
    if (g_log.size() > 0) chk("s5_restart", g_log[0], 4'b0001);
    else chk("s5_restart_seen", 0, 1);
    if (w_dat.size() >= 3) begin
      chk("s5_first", w_dat[0], 10);
      chk("s5_resume", w_dat[2], 3);
    end
    chk("s5_nwr", w_dat.size(), 6);

    // req = 1010 with rr_ptr = 0
    do_reset();
    clear_logs();
    pq[1].push_back(4'd1); pq[1].push_back(4'd2);
    pq[3].push_back(4'd3); pq[3].push_back(4'd4);
    drain(20);
    chk("s6_ngrants", g_log.size(), 2);
    if (g_log.size() >= 2) begin
      chk("s6_g0", g_log[0], 4'b0010);
      chk("s6_g1", g_log[1], 4'b1000);
    end

    // Random traffic, random full, occasional reset
    do_reset();
    clear_logs();
    for (int c = 0; c < 2000; c++) begin
      for (int i = 0; i < NR; i++)
        if ($urandom_range(3) == 0 && pq[i].size() < 5) pq[i].push_back(DW'($urandom));
      full_v = ($urandom_range(3) == 0);
      if ($urandom_range(299) == 0) do_reset();
      step();
    end
    full_v = 1'b0;
    drain(200);
    chk("rnd_viol", viol_cnt, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
